// File: rtl/red_send.sv
// NEC-format infrared transmitter: serialises a 32-bit word (or a repeat code)
// into mark/space envelope o_red plus a carrier-modulated LED drive o_ir_led.
module red_send #(
  parameter int unsigned LEAD_MARK_US  = 9000,
  parameter int unsigned LEAD_SPACE_US = 4500,
  parameter int unsigned RPT_SPACE_US  = 2250,
  parameter int unsigned BIT_MARK_US   = 560,
  parameter int unsigned ZERO_SPACE_US = 560,
  parameter int unsigned ONE_SPACE_US  = 1690,
  parameter int unsigned GAP_US        = 10000,
  parameter int unsigned CARR_PERIOD   = 26,
  parameter int unsigned CARR_HIGH     = 9
) (
  input  logic        i_clk_1us,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_start_rpt,
  input  logic [31:0] i_data,
  output logic        o_red,
  output logic        o_ir_led,
  output logic        o_busy,
  output logic        o_done
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BIT_W  = 5;
  localparam int unsigned CCNT_W = (CARR_PERIOD > 1) ? $clog2(CARR_PERIOD) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_MARK,
    S_LEAD_SPACE,
    S_BIT_MARK,
    S_BIT_SPACE,
    S_STOP_MARK,
    S_GAP
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  dur;
  logic [BIT_W-1:0]  bit_idx;
  logic [31:0]       shreg;
  logic              rpt;
  logic [CCNT_W-1:0] ccnt;
  logic              in_mark;
  logic              phase_end;

  // Length of the current phase and whether the line is in a mark
  always_comb begin
    dur     = CNT_W'(1);
    in_mark = 1'b0;
    case (state)
      S_LEAD_MARK: begin
        dur     = CNT_W'(LEAD_MARK_US);
        in_mark = 1'b1;
      end
      S_LEAD_SPACE: dur = rpt ? CNT_W'(RPT_SPACE_US) : CNT_W'(LEAD_SPACE_US);
      S_BIT_MARK: begin
        dur     = CNT_W'(BIT_MARK_US);
        in_mark = 1'b1;
      end
      S_BIT_SPACE: dur = shreg[0] ? CNT_W'(ONE_SPACE_US) : CNT_W'(ZERO_SPACE_US);
      S_STOP_MARK: begin
        dur     = CNT_W'(BIT_MARK_US);
        in_mark = 1'b1;
      end
      S_GAP: dur = CNT_W'(GAP_US);
      default: ;
    endcase
    phase_end = (cnt == dur - CNT_W'(1));
  end

  // Frame sequencer, datapath and registered line outputs
  always_ff @(posedge i_clk_1us or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      rpt      <= 1'b0;
      ccnt     <= '0;
      o_red    <= 1'b1;
      o_ir_led <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_done   <= 1'b0;
      // Outputs follow the registered state one cycle later, keeping them aligned
      o_red    <= ~in_mark;
      o_ir_led <= in_mark && (ccnt < CCNT_W'(CARR_HIGH));
      if (in_mark) begin
        ccnt <= (ccnt == CCNT_W'(CARR_PERIOD - 1)) ? '0 : ccnt + CCNT_W'(1);
      end else begin
        ccnt <= '0;
      end

      if (state == S_IDLE) begin
        if (i_start) begin
          shreg <= i_data;
          rpt   <= 1'b0;
        end else if (i_start_rpt) begin
          rpt   <= 1'b1;
        end
        if (i_start || i_start_rpt) begin
          state   <= S_LEAD_MARK;
          cnt     <= '0;
          bit_idx <= '0;
          o_busy  <= 1'b1;
        end
      end else if (!phase_end) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
        case (state)
          S_LEAD_MARK:  state <= S_LEAD_SPACE;
          S_LEAD_SPACE: state <= rpt ? S_STOP_MARK : S_BIT_MARK;
          S_BIT_MARK:   state <= S_BIT_SPACE;
          S_BIT_SPACE: begin
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + BIT_W'(1);
            state   <= (bit_idx == BIT_W'(31)) ? S_STOP_MARK : S_BIT_MARK;
          end
          S_STOP_MARK:  state <= S_GAP;
          S_GAP: begin
            state  <= S_IDLE;
            o_done <= 1'b1;
            o_busy <= 1'b0;
          end
          default:      state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_red_send.sv
// Scoreboard bench for red_send with shortened phase timings.
module tb_red_send;

  localparam int LM = 90;
  localparam int LS = 45;
  localparam int RS = 22;
  localparam int BM = 28;
  localparam int ZS = 12;
  localparam int OS = 36;
  localparam int GP = 100;
  localparam int CP = 26;
  localparam int CH = 9;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_start_rpt = 1'b0;
  logic [31:0] i_data = '0;
  logic        o_red, o_ir_led, o_busy, o_done;

  red_send #(
    .LEAD_MARK_US(LM), .LEAD_SPACE_US(LS), .RPT_SPACE_US(RS),
    .BIT_MARK_US(BM), .ZERO_SPACE_US(ZS), .ONE_SPACE_US(OS),
    .GAP_US(GP), .CARR_PERIOD(CP), .CARR_HIGH(CH)
  ) dut (
    .i_clk_1us(clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_start_rpt(i_start_rpt), .i_data(i_data),
    .o_red(o_red), .o_ir_led(o_ir_led), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_end;
    bit          lvl;
    int          len;
    bit          is_rpt;
    logic [31:0] data;
    int          busy_len;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   done_count = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at %0t",
               name, act, act, req, req, $time);
    end
  endtask

  task automatic push_run(input bit lvl, input int len, inout int total);
    exp_t e;
    e = '{is_end: 1'b0, lvl: lvl, len: len, is_rpt: 1'b0, data: '0, busy_len: 0};
    exp_q.push_back(e);
    total += len;
  endtask

  // Reference: expected envelope runs for one frame, then the end-of-frame record
  task automatic push_frame(input logic [31:0] d, input bit rpt);
    int   total;
    exp_t e;
    total = 0;
    push_run(1'b0, LM, total);
    push_run(1'b1, rpt ? RS : LS, total);
    if (!rpt) begin
      for (int i = 0; i < 32; i++) begin
        push_run(1'b0, BM, total);
        push_run(1'b1, d[i] ? OS : ZS, total);
      end
    end
    push_run(1'b0, BM, total);
    e = '{is_end: 1'b1, lvl: 1'b1, len: GP, is_rpt: rpt, data: d, busy_len: total + GP};
    exp_q.push_back(e);
  endtask

  // Monitor: measure envelope runs, carrier shape, decode payload, score on o_done
  bit          prev_red = 1'b1;
  bit          in_frame = 1'b0;
  int          run_len = 0;
  int          run_no = 0;
  int          busy_cnt = 0;
  logic [31:0] dec = '0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!i_rst_n) begin
        prev_red = 1'b1;
        in_frame = 1'b0;
        run_len  = 0;
        busy_cnt = 0;
      end else begin
        if (o_busy) busy_cnt++;
        if (o_red != prev_red) begin
          if (in_frame) begin
            if (exp_q.size() == 0) begin
              check("unexpected_run", 1, 0);
            end else begin
              e = exp_q.pop_front();
              check("run_is_phase", e.is_end, 0);
              check("run_level", prev_red, e.lvl);
              check("run_length", run_len, e.len);
            end
            if (prev_red && run_no >= 3) dec = {(run_len > (ZS + OS) / 2), dec[31:1]};
            run_no++;
          end else if (!o_red) begin
            in_frame = 1'b1;
            run_no   = 0;
            dec      = '0;
          end
          prev_red = o_red;
          run_len  = 1;
        end else begin
          run_len++;
        end
        if (o_red) check("led_off_in_space", o_ir_led, 0);
        else check("led_carrier", o_ir_led, ((run_len - 1) % CP) < CH);
        if (o_done) begin
          done_count++;
          if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("done_at_frame_end", e.is_end, 1);
            check("gap_length", o_red ? run_len : -1, e.len);
            check("busy_length", busy_cnt, e.busy_len);
            if (!e.is_rpt) check("payload", dec, e.data);
            else check("rpt_no_bits", run_no, 3);
          end
          check("busy_low_at_done", o_busy, 0);
          in_frame = 1'b0;
          busy_cnt = 0;
        end
      end
    end
  end

  // Issue one request, check acceptance latency, then scramble i_data
  task automatic send(input logic [31:0] d, input bit st, input bit rp, input bit hold);
    @(negedge clk);
    i_data      = d;
    i_start     = st;
    i_start_rpt = rp;
    push_frame(d, !st);
    @(posedge clk);
    #1;
    check("busy_rise", o_busy, 1);
    check("red_before_mark", o_red, 1);
    if (!hold) begin
      i_start     = 1'b0;
      i_start_rpt = 1'b0;
    end
    i_data = $urandom;
    @(posedge clk);
    #1;
    check("red_fall_latency", o_red, 0);
    check("led_first_mark_cycle", o_ir_led, 1);
  endtask

  task automatic wait_done(input int limit);
    int c0;
    int n;
    c0 = done_count;
    n  = 0;
    while (done_count == c0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    check("done_within_budget", done_count != c0, 1);
  endtask

  initial begin
    logic [31:0] d;
    bit          rp;
    int          t;

    #12;
    check("rst_red", o_red, 1);
    check("rst_led", o_ir_led, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    @(negedge clk);
    i_rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_red", o_red, 1);

    send(32'h00FF_A55A, 1'b1, 1'b0, 1'b0);
    wait_done(5000);

    send(32'h0, 1'b0, 1'b1, 1'b0);
    wait_done(5000);

    // Both requests together: full frame wins
    send(32'h12ED_40BF, 1'b1, 1'b1, 1'b0);
    wait_done(5000);

    send(32'h0000_0000, 1'b1, 1'b0, 1'b0);
    wait_done(5000);
    send(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    wait_done(5000);

    // Requests while busy are ignored
    send(32'hCAFE_0123, 1'b1, 1'b0, 1'b0);
    repeat (300) @(posedge clk);
    @(negedge clk);
    i_data = 32'h5555_AAAA;
    i_start = 1'b1;
    i_start_rpt = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_start_rpt = 1'b0;
    wait_done(5000);

    for (int k = 0; k < 6; k++) begin
      d  = $urandom;
      rp = ($urandom_range(0, 3) == 0);
      send(d, !rp, rp, 1'b0);
      wait_done(5000);
    end

    // Back-to-back with i_start held: one IDLE cycle between frames
    send(32'h0BAD_F00D, 1'b1, 1'b0, 1'b1);
    i_data = 32'h7654_3210;
    push_frame(32'h7654_3210, 1'b0);
    wait_done(5000);
    #1;
    check("b2b_reaccept", o_busy, 1);
    i_start = 1'b0;
    wait_done(5000);

    // Reset in bit 17's space aborts the frame
    d = 32'h9A3C_5E71;
    send(d, 1'b1, 1'b0, 1'b0);
    t = LM + LS + BM;
    for (int i = 0; i < 17; i++) t += BM + (d[i] ? OS : ZS);
    repeat (t) @(posedge clk);
    #2;
    check("pre_abort_space", o_red, 1);
    i_rst_n = 1'b0;
    #1;
    check("abort_red", o_red, 1);
    check("abort_busy", o_busy, 0);
    check("abort_led", o_ir_led, 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
    repeat (2 * GP) @(posedge clk);
    check("no_done_after_abort", done_count, 14);

    send(32'h1357_9BDF, 1'b1, 1'b0, 1'b0);
    wait_done(5000);

    repeat (3 * GP) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("total_done_pulses", done_count, 15);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
